spi_slave_rx: RTL
=================

# spi_slave_rx

SPI mode-0 slave front end that deserializes MOSI bytes into the CSR core's byte interface and serializes CSR read data back onto MISO. Sits directly upstream of the CSR core logic: its `data_rx` and `data_rdy` drive the core's byte input and ready strobe, and it consumes the core's `data_out` and `data_latch`. All SPI pins are asynchronous to `clk` and are oversampled.

## Interface
- `DATA_WIDTH`, 8, bits per SPI frame/byte (≥2)
- `CNT_WIDTH`, 4, bit-counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH
- `clk`  in  1  system clock
- `rst_bar`  in  1  asynchronous, active-low reset
- `sclk`  in  1  SPI clock (CPOL=0), asynchronous
- `cs_n`  in  1  SPI chip select, active low, asynchronous
- `mosi`  in  1  SPI data in, asynchronous
- `miso`  out  1  SPI data out
- `miso_oe`  out  1  MISO output enable; high only while selected
- `data_rx`  out  DATA_WIDTH  last complete received byte (to core `data_in`)
- `data_rdy`  out  1  one-cycle pulse: `data_rx` updated
- `data_tx`  in  DATA_WIDTH  byte to return on MISO (from core `data_out`)
- `data_latch`  in  1  level/pulse; while high, `data_tx` is captured into the TX buffer
- `rx_overrun`  out  1  sticky: a byte completed while the previous `data_rdy` was unacknowledged (see Operation)

## Operation
- Sync: `sclk`, `cs_n`, `mosi` each through 2-FF synchronizer; a third `sclk` register gives rise/fall detect. `cs_n` sync resets to 1.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: `miso_oe`=0. On synced `cs_n` falling → load TX shift reg from TX buffer (or 0x00 if buffer empty), clear bit counter, `miso_oe`=1, → SHIFT.
  - SHIFT: on `sclk` rise, shift synced `mosi` into RX shift reg, counter+1. On `sclk` fall, shift TX reg, drive next bit on `miso`. When counter reaches DATA_WIDTH on a rise → DONE.
  - DONE (1 cycle): `data_rx` ← RX shift reg, `data_rdy`=1, counter cleared, TX shift reg reloaded from TX buffer (or 0x00) → SHIFT if `cs_n` still low, else IDLE.
- `cs_n` rise in SHIFT (any count): abort; partial byte discarded, no `data_rdy`, `miso_oe`=0, → IDLE. `cs_n` rise coinciding with DONE: DONE completes normally, then IDLE.
- TX buffer: `data_latch`=1 on a clk edge writes `data_tx` and sets buffer-full; consumed (full cleared) at each TX reg load. Latch and consume in same cycle: old value consumed, new value stored, full stays 1.
- Overrun: `rx_overrun` sets if two `data_rdy` pulses occur with no `data_latch` between them and the first frame's op bits (`data_rx[7:6]`) were nonzero; cleared only by reset.
- Reset: `miso`=0, `miso_oe`=0, `data_rx`=0, `data_rdy`=0, `rx_overrun`=0, TX buffer empty, FSM IDLE.

## Timing
- SCLK frequency ≤ clk/6; each SCLK high and low phase ≥ 3 clk cycles.
- `cs_n` fall to first `sclk` rise ≥ 4 clk cycles (sync + MISO first bit settle).
- `data_rdy` asserts 4 clk cycles after the last-bit SCLK rising edge at the pin (2 sync + 1 edge + 1 DONE).
- `data_latch` must arrive ≥ 1 clk before the DONE cycle of the current byte for its data to be sent in the next byte; later → sent one byte later.
- First MISO bit valid at the pin 3 clk after `cs_n` fall; subsequent bits change 3 clk after each SCLK falling edge.

## Configuration
- `SPI_LSB_FIRST_EN`: defined → RX and TX shift LSB first (RX shifts right, MISO drives bit 0). Undefined (default) → MSB first. No other behaviour changes.

## Test plan
- Reset, `cs_n` low, send 0xA5 MSB-first at clk/8 → one `data_rdy` pulse, `data_rx`=0xA5, `rx_overrun`=0, `miso` bits all 0.
- Pulse `data_latch` with `data_tx`=0x3C, then send two bytes 0x40,0x00 in one `cs_n` frame → MISO returns 0x3C on byte 1, 0x00 on byte 2; `data_rdy` twice.
- Raise `cs_n` after 5 bits → no `data_rdy`, `miso_oe`=0 within 3 clk; next full byte 0x81 received correctly.
- Send 0xC0 then 0x12 with no `data_latch` → `rx_overrun`=1 after second `data_rdy`; stays 1 until `rst_bar` low.
- Assert `rst_bar` low mid-byte (bit 3) → all outputs reset immediately (async); after release, 0x5A received correctly.
- With `SPI_LSB_FIRST_EN` defined, send bit stream 1,0,1,0,0,0,0,0 → `data_rx`=0x05.

Source files
------------

// File: rtl/spi_slave_rx_if.sv
// SPI pins plus the byte-side handshake between the SPI receiver and the CSR core.
`timescale 1ns/1ps
interface spi_slave_rx_if #(parameter int DATA_WIDTH = 8);
    logic                  sclk;
    logic                  cs_n;
    logic                  mosi;
    logic                  miso;
    logic                  miso_oe;
    logic [DATA_WIDTH-1:0] data_rx;
    logic                  data_rdy;
    logic [DATA_WIDTH-1:0] data_tx;
    logic                  data_latch;
    logic                  rx_overrun;

    modport slave (
        input  sclk, cs_n, mosi, data_tx, data_latch,
        output miso, miso_oe, data_rx, data_rdy, rx_overrun
    );
    modport master (
        output sclk, cs_n, mosi, data_tx, data_latch,
        input  miso, miso_oe, data_rx, data_rdy, rx_overrun
    );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: oversampled deserializer to the CSR byte interface, with MISO return path.
// Optional SPI_LSB_FIRST_EN selects LSB-first shifting on both directions.
`timescale 1ns/1ps
module spi_slave_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 4
) (
    input logic          clk,
    input logic          rst_bar,
    spi_slave_rx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

`ifdef SPI_LSB_FIRST_EN
    localparam int TX_BIT  = 0;
    localparam int TX_NEXT = 1;
`else
    localparam int TX_BIT  = DATA_WIDTH - 1;
    localparam int TX_NEXT = DATA_WIDTH - 2;
`endif

    state_t                state;
    logic [2:0]            sclk_q;
    logic [1:0]            cs_q;
    logic [1:0]            mosi_q;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [DATA_WIDTH-1:0] rx_sr, tx_sr, tx_buf, data_rx_q;
    logic [DATA_WIDTH-1:0] rx_shifted, tx_shifted, tx_load;
    logic                  tx_full, pending, overrun_q;
    logic                  miso_q, miso_oe_q, data_rdy_q;
    logic                  sclk_rise, sclk_fall, selected, tx_take;

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            sclk_q <= '0;
            cs_q   <= '1;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], bus.sclk};
            cs_q   <= {cs_q[0], bus.cs_n};
            mosi_q <= {mosi_q[0], bus.mosi};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign selected  = ~cs_q[1];
    assign tx_load   = tx_full ? tx_buf : '0;
    assign tx_take   = selected && (state == IDLE || state == DONE);

`ifdef SPI_LSB_FIRST_EN
    assign rx_shifted = {mosi_q[1], rx_sr[DATA_WIDTH-1:1]};
    assign tx_shifted = {1'b0, tx_sr[DATA_WIDTH-1:1]};
`else
    assign rx_shifted = {rx_sr[DATA_WIDTH-2:0], mosi_q[1]};
    assign tx_shifted = {tx_sr[DATA_WIDTH-2:0], 1'b0};
`endif

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            state      <= IDLE;
            cnt        <= '0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
            data_rx_q  <= '0;
            data_rdy_q <= 1'b0;
        end else begin
            data_rdy_q <= 1'b0;
            case (state)
                IDLE: begin
                    miso_q    <= 1'b0;
                    miso_oe_q <= 1'b0;
                    if (selected) begin
                        tx_sr     <= tx_load;
                        miso_q    <= tx_load[TX_BIT];
                        miso_oe_q <= 1'b1;
                        cnt       <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!selected) begin
                        miso_q    <= 1'b0;
                        miso_oe_q <= 1'b0;
                        state     <= IDLE;
                    end else if (sclk_rise) begin
                        rx_sr <= rx_shifted;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CNT_WIDTH'(DATA_WIDTH - 1))
                            state <= DONE;
                    end else if (sclk_fall && cnt != '0) begin
                        // The fall trailing a byte's last rise (cnt==0) must not
                        // shift away the next byte's first bit loaded in DONE.
                        tx_sr  <= tx_shifted;
                        miso_q <= tx_sr[TX_NEXT];
                    end
                end
                DONE: begin
                    data_rx_q  <= rx_sr;
                    data_rdy_q <= 1'b1;
                    cnt        <= '0;
                    if (selected) begin
                        tx_sr  <= tx_load;
                        miso_q <= tx_load[TX_BIT];
                        state  <= SHIFT;
                    end else begin
                        // Leaving the frame: keep the TX buffer for the next select.
                        miso_q    <= 1'b0;
                        miso_oe_q <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            tx_buf    <= '0;
            tx_full   <= 1'b0;
            pending   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (bus.data_latch) begin
                tx_buf  <= bus.data_tx;
                tx_full <= 1'b1;
            end else if (tx_take) begin
                tx_full <= 1'b0;
            end
            // pending: last delivered byte carried op bits and no latch has answered it yet
            if (state == DONE) begin
                if (pending && !bus.data_latch)
                    overrun_q <= 1'b1;
                pending <= |rx_sr[DATA_WIDTH-1:DATA_WIDTH-2];
            end else if (bus.data_latch) begin
                pending <= 1'b0;
            end
        end
    end

    assign bus.miso       = miso_q;
    assign bus.miso_oe    = miso_oe_q;
    assign bus.data_rx    = data_rx_q;
    assign bus.data_rdy   = data_rdy_q;
    assign bus.rx_overrun = overrun_q;
endmodule
